// File: rtl/mips_datapath_controller_pkg.sv
// Shared definitions for the single-cycle MIPS-style execution core.
// Holds opcode constants, ALU control codes, instruction field positions
// and the immediate sign-extension helper.
package mips_datapath_controller_pkg;

  // Instruction field positions
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  // Opcodes
  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SUB = 6'b000010;
  localparam logic [5:0] OP_INC = 6'b000011;
  localparam logic [5:0] OP_DEC = 6'b000100;
  localparam logic [5:0] OP_AND = 6'b000101;
  localparam logic [5:0] OP_OR  = 6'b000110;
  localparam logic [5:0] OP_XOR = 6'b000111;
  localparam logic [5:0] OP_NOT = 6'b001000;
  localparam logic [5:0] OP_SLL = 6'b001001;
  localparam logic [5:0] OP_SRL = 6'b001010;
  localparam logic [5:0] OP_LW  = 6'b100010;
  localparam logic [5:0] OP_SW  = 6'b100100;

  // ALU operation codes
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_INC = 4'd2,
    ALU_DEC = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_NOT = 4'd7,
    ALU_SLL = 4'd8,
    ALU_SRL = 4'd9
  } alu_ctrl_e;

  // Sign-extend a 16-bit immediate to 32 bits
  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_datapath_controller_controller.sv
// Combinational opcode decoder.
// Ports:
//   op          - 6-bit opcode
//   Reg_Dst     - 1: write rd, 0: write rt
//   Reg_Write   - register file write enable
//   Alu_Src     - 1: ALU B is the sign-extended immediate
//   Mem_Write   - data memory write enable
//   Mem_Read    - data memory read enable (read data forced to 0 otherwise)
//   Mem_To_Reg  - 1: write-back value comes from memory
//   Shamt_Sel   - 1: ALU B is the zero-extended shift amount
//   Alu_Control - ALU operation code
module mips_datapath_controller_controller
  import mips_datapath_controller_pkg::*;
(
  input  logic [5:0] op,
  output logic       Reg_Dst,
  output logic       Reg_Write,
  output logic       Alu_Src,
  output logic       Mem_Write,
  output logic       Mem_Read,
  output logic       Mem_To_Reg,
  output logic       Shamt_Sel,
  output logic [3:0] Alu_Control
);

  // Opcode decode; unknown opcodes leave every write disabled and select ADD
  always_comb begin
    Reg_Dst     = 1'b0;
    Reg_Write   = 1'b0;
    Alu_Src     = 1'b0;
    Mem_Write   = 1'b0;
    Mem_Read    = 1'b0;
    Mem_To_Reg  = 1'b0;
    Shamt_Sel   = 1'b0;
    Alu_Control = ALU_ADD;
    case (op)
      OP_ADD: begin Reg_Dst = 1'b1; Reg_Write = 1'b1; Alu_Control = ALU_ADD; end
      OP_SUB: begin Reg_Dst = 1'b1; Reg_Write = 1'b1; Alu_Control = ALU_SUB; end
      OP_AND: begin Reg_Dst = 1'b1; Reg_Write = 1'b1; Alu_Control = ALU_AND; end
      OP_OR:  begin Reg_Dst = 1'b1; Reg_Write = 1'b1; Alu_Control = ALU_OR;  end
      OP_XOR: begin Reg_Dst = 1'b1; Reg_Write = 1'b1; Alu_Control = ALU_XOR; end
      OP_INC: begin Reg_Write = 1'b1; Alu_Control = ALU_INC; end
      OP_DEC: begin Reg_Write = 1'b1; Alu_Control = ALU_DEC; end
      OP_NOT: begin Reg_Write = 1'b1; Alu_Control = ALU_NOT; end
      OP_SLL: begin
        Reg_Dst = 1'b1; Reg_Write = 1'b1; Shamt_Sel = 1'b1; Alu_Control = ALU_SLL;
      end
      OP_SRL: begin
        Reg_Dst = 1'b1; Reg_Write = 1'b1; Shamt_Sel = 1'b1; Alu_Control = ALU_SRL;
      end
      OP_LW: begin
        Reg_Write = 1'b1; Alu_Src = 1'b1; Mem_Read = 1'b1; Mem_To_Reg = 1'b1;
        Alu_Control = ALU_ADD;
      end
      OP_SW: begin
        Alu_Src = 1'b1; Mem_Write = 1'b1; Alu_Control = ALU_ADD;
      end
      default: begin
        Alu_Control = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/mips_datapath_controller_datapath.sv
// Datapath: 32x32 register file (2 async read, 1 sync write), ALU,
// sign-extend, operand/write-back muxes and 32-word data memory.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   fields      - instruction bits [25:0] (rs, rt, rd, shamt, imm)
//   control     - decoded control signals from the controller
//   data_out    - write-back value (memory data for loads, ALU result otherwise)
module mips_datapath_controller_datapath
  import mips_datapath_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [25:0] fields,
  input  logic        Reg_Dst,
  input  logic        Reg_Write,
  input  logic        Alu_Src,
  input  logic        Mem_Write,
  input  logic        Mem_Read,
  input  logic        Mem_To_Reg,
  input  logic        Shamt_Sel,
  input  logic [3:0]  Alu_Control,
  output logic [31:0] data_out
);

  logic [31:0] reg_file_r [32];
  logic [31:0] mem_r      [32];

  logic [4:0]  rs_s, rt_s, rd_s, shamt_s, wr_addr_s, mem_addr_s;
  logic [15:0] imm_s;
  logic [31:0] rs_data_s, rt_data_s, alu_b_s, alu_res_s, mem_rd_s;

  assign rs_s    = fields[RS_MSB:RS_LSB];
  assign rt_s    = fields[RT_MSB:RT_LSB];
  assign rd_s    = fields[RD_MSB:RD_LSB];
  assign shamt_s = fields[SHAMT_MSB:SHAMT_LSB];
  assign imm_s   = fields[IMM_MSB:IMM_LSB];

  assign rs_data_s  = reg_file_r[rs_s];
  assign rt_data_s  = reg_file_r[rt_s];
  assign wr_addr_s  = Reg_Dst ? rd_s : rt_s;
  // Only the low five address bits select a word, so addresses wrap
  assign mem_addr_s = alu_res_s[4:0];

  // ALU B operand select: shift amount, immediate or rt
  always_comb begin
    alu_b_s = rt_data_s;
    if (Shamt_Sel) begin
      alu_b_s = {27'd0, shamt_s};
    end else if (Alu_Src) begin
      alu_b_s = sign_ext16(imm_s);
    end else begin
      alu_b_s = rt_data_s;
    end
  end

  // ALU; all arithmetic wraps modulo 2^32
  always_comb begin
    alu_res_s = 32'd0;
    case (Alu_Control)
      ALU_ADD: alu_res_s = rs_data_s + alu_b_s;
      ALU_SUB: alu_res_s = rs_data_s - alu_b_s;
      ALU_INC: alu_res_s = rs_data_s + 32'd1;
      ALU_DEC: alu_res_s = rs_data_s - 32'd1;
      ALU_AND: alu_res_s = rs_data_s & alu_b_s;
      ALU_OR:  alu_res_s = rs_data_s | alu_b_s;
      ALU_XOR: alu_res_s = rs_data_s ^ alu_b_s;
      ALU_NOT: alu_res_s = ~rs_data_s;
      ALU_SLL: alu_res_s = rs_data_s << alu_b_s[4:0];
      ALU_SRL: alu_res_s = rs_data_s >> alu_b_s[4:0];
      default: alu_res_s = rs_data_s + alu_b_s;
    endcase
  end

  // Memory read data and write-back select
  always_comb begin
    mem_rd_s = 32'd0;
    if (Mem_Read) begin
      mem_rd_s = mem_r[mem_addr_s];
    end else begin
      mem_rd_s = 32'd0;
    end
    data_out = Mem_To_Reg ? mem_rd_s : alu_res_s;
  end

  // Register file write port; reset clears all registers (r0 is writable)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        reg_file_r[i] <= 32'd0;
      end
    end else if (Reg_Write) begin
      reg_file_r[wr_addr_s] <= data_out;
    end
  end

  // Data memory write port; reset loads word i with value i
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_r[i] <= 32'(i);
      end
    end else if (Mem_Write) begin
      mem_r[mem_addr_s] <= rt_data_s;
    end
  end

endmodule

// File: rtl/mips_datapath_controller.sv
// Single-cycle, non-branching MIPS-style execution core.
// Ports:
//   clk      - system clock, state updates on rising edge
//   rst      - asynchronous active-high reset
//   Instr    - instruction executed at the next rising edge
//   Data_Out - combinational write-back value
module mips_datapath_controller
  import mips_datapath_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  output logic [31:0] Data_Out
);

  logic       reg_dst_s, reg_write_s, alu_src_s, mem_write_s;
  logic       mem_read_s, mem_to_reg_s, shamt_sel_s;
  logic [3:0] alu_control_s;

  mips_datapath_controller_controller u_controller (
    .op          (Instr[OP_MSB:OP_LSB]),
    .Reg_Dst     (reg_dst_s),
    .Reg_Write   (reg_write_s),
    .Alu_Src     (alu_src_s),
    .Mem_Write   (mem_write_s),
    .Mem_Read    (mem_read_s),
    .Mem_To_Reg  (mem_to_reg_s),
    .Shamt_Sel   (shamt_sel_s),
    .Alu_Control (alu_control_s)
  );

  mips_datapath_controller_datapath u_datapath (
    .clk         (clk),
    .rst         (rst),
    .fields      (Instr[RS_MSB:IMM_LSB]),
    .Reg_Dst     (reg_dst_s),
    .Reg_Write   (reg_write_s),
    .Alu_Src     (alu_src_s),
    .Mem_Write   (mem_write_s),
    .Mem_Read    (mem_read_s),
    .Mem_To_Reg  (mem_to_reg_s),
    .Shamt_Sel   (shamt_sel_s),
    .Alu_Control (alu_control_s),
    .data_out    (Data_Out)
  );

endmodule

// File: tb/tb_mips_datapath_controller.sv
// Self-checking bench for mips_datapath_controller. Each instruction pushes
// its expected Data_Out into a scoreboard queue when driven; the entry is
// popped and compared on the following falling edge.
module tb_mips_datapath_controller;

  logic        clk;
  logic        rst;
  logic [31:0] Instr;
  logic [31:0] Data_Out;

  int errors_r = 0;
  int checks_r = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  localparam logic [5:0] UNDEF = 6'b111111;

  mips_datapath_controller dut (
    .clk      (clk),
    .rst      (rst),
    .Instr    (Instr),
    .Data_Out (Data_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_r++;
    if (act !== exp) begin
      errors_r++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {op, rs, rt, rd, sh, 6'd0};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Drive one instruction (called at posedge+1), compare at negedge, commit at posedge
  task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] exp);
    sb_entry_t e;
    Instr = ins;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, Data_Out, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Read a register without writing anything: undefined op gives rs + r31 (r31 stays 0)
  task automatic read_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    run(tag, r_ins(UNDEF, r, 5'd31, 5'd0, 5'd0), exp);
  endtask

  initial begin
    rst   = 1'b1;
    Instr = r_ins(UNDEF, 5'd1, 5'd2, 5'd0, 5'd0);
    #2;
    check_eq("rst_regs", Data_Out, 32'd0);
    Instr = i_ins(6'b100010, 5'd0, 5'd0, 16'd7);
    #1;
    check_eq("rst_mem7", Data_Out, 32'd7);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run("lw_r0",  i_ins(6'b100010, 5'd1, 5'd0, 16'd1), 32'd1);
    run("lw_r1",  i_ins(6'b100010, 5'd2, 5'd1, 16'd1), 32'd1);
    run("add_r3", r_ins(6'b000001, 5'd0, 5'd1, 5'd3, 5'd0), 32'd2);
    run("lw_r4",  i_ins(6'b100010, 5'd4, 5'd4, 16'd10), 32'd10);
    run("lw_r5",  i_ins(6'b100010, 5'd5, 5'd5, 16'd9), 32'd9);
    run("sub_r6", r_ins(6'b000010, 5'd4, 5'd5, 5'd6, 5'd0), 32'd1);
    run("lw_r7",  i_ins(6'b100010, 5'd7, 5'd7, 16'd4), 32'd4);
    run("inc_r9", r_ins(6'b000011, 5'd7, 5'd9, 5'd0, 5'd0), 32'd5);
    run("lw_r8",  i_ins(6'b100010, 5'd8, 5'd8, 16'd5), 32'd5);
    run("dec_r10", r_ins(6'b000100, 5'd8, 5'd10, 5'd0, 5'd0), 32'd4);
    run("sw_21",  i_ins(6'b100100, 5'd0, 5'd3, 16'd20), 32'd21);
    run("lw_r11", i_ins(6'b100010, 5'd0, 5'd11, 16'd20), 32'd2);
    run("lw_wrap", i_ins(6'b100010, 5'd31, 5'd12, 16'd33), 32'd1);
    run("and",    r_ins(6'b000101, 5'd4, 5'd5, 5'd13, 5'd0), 32'd8);
    run("or",     r_ins(6'b000110, 5'd4, 5'd5, 5'd14, 5'd0), 32'd11);
    run("xor",    r_ins(6'b000111, 5'd4, 5'd5, 5'd15, 5'd0), 32'd3);
    run("not",    r_ins(6'b001000, 5'd4, 5'd16, 5'd0, 5'd0), 32'hFFFF_FFF5);
    run("sll",    r_ins(6'b001001, 5'd4, 5'd0, 5'd17, 5'd3), 32'd80);
    run("srl",    r_ins(6'b001010, 5'd4, 5'd0, 5'd18, 5'd1), 32'd5);
    run("sw_neg", i_ins(6'b100100, 5'd4, 5'd5, 16'hFFF0), 32'hFFFF_FFFA);
    run("lw_26",  i_ins(6'b100010, 5'd31, 5'd19, 16'd26), 32'd9);

    read_reg("rd_r3",  5'd3,  32'd2);
    read_reg("rd_r6",  5'd6,  32'd1);
    read_reg("rd_r9",  5'd9,  32'd5);
    read_reg("rd_r10", 5'd10, 32'd4);
    read_reg("rd_r11", 5'd11, 32'd2);
    read_reg("rd_r12", 5'd12, 32'd1);
    read_reg("rd_r16", 5'd16, 32'hFFFF_FFF5);
    read_reg("rd_r17", 5'd17, 32'd80);
    read_reg("rd_r18", 5'd18, 32'd5);
    read_reg("rd_r19", 5'd19, 32'd9);

    // Same-cycle read of the register being written returns the old value
    run("inc_self", r_ins(6'b000011, 5'd9, 5'd9, 5'd0, 5'd0), 32'd6);
    read_reg("rd_r9b", 5'd9, 32'd6);

    // Undefined opcode: ADD of rs,rt and no state change
    run("undef", r_ins(UNDEF, 5'd3, 5'd3, 5'd3, 5'd0), 32'd4);
    read_reg("undef_r3", 5'd3, 32'd2);
    run("undef_mem", i_ins(6'b100010, 5'd31, 5'd20, 16'd21), 32'd2);

    // Asynchronous reset mid-sequence
    Instr = i_ins(6'b100010, 5'd4, 5'd20, 16'd0);
    #1;
    check_eq("pre_rst", Data_Out, 32'd10);
    rst = 1'b1;
    #1;
    check_eq("async_rst", Data_Out, 32'd0);
    Instr = r_ins(6'b000011, 5'd0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    read_reg("rst_r0",  5'd0,  32'd0);
    read_reg("rst_r17", 5'd17, 32'd0);
    run("rst_m21", i_ins(6'b100010, 5'd31, 5'd20, 16'd21), 32'd21);
    run("rst_m26", i_ins(6'b100010, 5'd31, 5'd21, 16'd26), 32'd26);

    $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
    $finish;
  end

endmodule

// File: doc/mips_datapath_controller.md
# mips_datapath_controller

Single-cycle, non-branching MIPS-style execution core: combinational controller decoding a 6-bit opcode plus datapath with 32×32 register file, ALU and 32-word data memory. Instructions arrive externally each cycle on `Instr` (no PC/fetch). Architectural state updates on each rising clock edge. Used as the compute core under the top-level processor.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register index, 32-word data memory.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `Instr`  input  32  current instruction, held stable across the rising edge that executes it.
- `Data_Out`  output  32  combinational write-back value: memory read data for LW, ALU result otherwise.

## Operation
- Fields: `op=Instr[31:26]`, `rs=[25:21]`, `rt=[20:16]`, `rd=[15:11]`, `shamt=[10:6]`, `imm=[15:0]`, sign-extended to 32 bits.
- Controller outputs: `Reg_Dst`, `Reg_Write`, `Alu_Src`, `Mem_Write`, `Mem_Read`, `Mem_To_Reg`, `Shamt_Sel`, `Alu_Control[3:0]`.
- `Alu_Control` encoding:
  - ADD=0, SUB=1, INC=2, DEC=3, AND=4, OR=5, XOR=6, NOT=7, SLL=8, SRL=9.
  - LW and SW use ADD.
- Opcodes and effects (all arithmetic 32-bit, wraps modulo 2^32):
  - ADD 000001: `rd=rs+rt`.
  - SUB 000010: `rd=rs-rt`.
  - AND 000101, OR 000110, XOR 000111: `rd=rs op rt`.
  - INC 000011: `rt=rs+1`.
  - DEC 000100: `rt=rs-1`.
  - NOT 001000: `rt=~rs`.
  - SLL 001001: `rd=rs<<shamt`, logical; `Shamt_Sel=1` selects zero-extended shamt as ALU B.
  - SRL 001010: `rd=rs>>shamt`, logical.
  - LW 100010: `rt=mem[(rs+imm)[4:0]]`.
  - SW 100100: `mem[(rs+imm)[4:0]]=rt`.
  - Any other opcode: no register or memory write; `Data_Out` = ALU ADD of rs,rt.
- Write destination by instruction group:
  - Two-operand ALU ops and shifts write rd (`Reg_Dst=1`).
  - INC/DEC/NOT/LW write rt (`Reg_Dst=0`).
- `Alu_Src=1` for LW/SW only (immediate operand).
- `Mem_Read=1`, `Mem_To_Reg=1` for LW only. When `Mem_Read=0`, memory read data is 0.
- Register file:
  - 2 combinational read ports, 1 synchronous write port.
  - Register 0 is an ordinary writable register (not hardwired).
- Data memory:
  - Word-addressed, combinational read, synchronous write.
  - Address uses ALU result bits [4:0]; higher bits ignored, so addresses wrap.

## Timing
- Control, ALU, memory read and `Data_Out` are combinational from `Instr` and current state.
- Register or memory write commits at the rising edge. The result is visible to the next instruction, so there is no hazard; latency is one cycle.
- Reset (async assert, effective immediately, held while `rst=1`):
  - All 32 registers = 0.
  - Memory word i = i (i=0..31).
  - No writes occur while reset is high.
- Reset asserted mid-sequence discards any pending write at that edge.
- Read of a register being written in the same cycle returns the old value.

## Structure
- Shared package holds opcode constants, `Alu_Control` codes and field-position constants.
- Natural split:
  - `controller` sub-module (pure combinational opcode decode).
  - Datapath containing register file, ALU, sign-extend, muxes and data memory.
- The top wires the two together.

## Test plan
- Reset, then LW r0←mem[r1+1]; LW r1←mem[r2+1]; ADD r3=r0+r1 -> `Data_Out` 1, 1, 2; r3=2.
- LW r4←mem[r4+10] (10), LW r5←mem[r5+9] (9), SUB rd=6 -> r6=1.
- LW r7←mem[r7+4]=4; INC rs=7, rt=9 -> r9=5. LW r8←mem[5]=5; DEC rs=8, rt=10 -> r10=4.
- SW rs=0, rt=3, imm=20 after above, then LW rt=11, rs=0, imm=20 -> r11=2. LW with rs+imm=33 reads mem[1]=1 (wrap).
- AND/OR/XOR/NOT/SLL/SRL on r4=10, r5=9:
  - AND=8, OR=11, XOR=3.
  - NOT r4=0xFFFFFFF5.
  - SLL shamt 3 =80, SRL shamt 1 =5.
- Assert `rst` asynchronously mid-sequence -> all registers 0 and memory restored immediately; undefined opcode 111111 -> no state change.
